vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Raster timing generator for the VGA output path: divides CLK_50 into a pixel-rate
//   enable and runs horizontal/vertical counters to produce h_sync, v_sync, pixel
//   coordinates and the display-area qualifier. Sits directly upstream of the VGA
//   colour stage, which consumes CounterX/CounterY/InDisplayArea to drive RED/GREEN/BLUE.
// PARAMETERS
//   CLK_DIV    2    CLK_50 cycles per pixel (>=1); 2 gives 25 MHz pixel rate
//   H_VISIBLE  640  visible pixels per line
//   H_FRONT    16   horizontal front porch (pixels)
//   H_SYNC     96   horizontal sync width (pixels)
//   H_BACK     48   horizontal back porch (pixels)
//   V_VISIBLE  480  visible lines per frame
//   V_FRONT    10   vertical front porch (lines)
//   V_SYNC     2    vertical sync width (lines)
//   V_BACK     33   vertical back porch (lines)
//   HSYNC_POL  0    active level of h_sync (0 = active-low)
//   VSYNC_POL  0    active level of v_sync (0 = active-low)
// PORTS
//   CLK_50         in   1   system clock, 50 MHz
//   RST            in   1   asynchronous reset, active-high
//   pix_en         out  1   one-CLK_50-cycle pulse per pixel; counters/outputs change only on it
//   CounterX       out  10  horizontal count, 0..H_TOTAL-1
//   CounterY       out  10  vertical count, 0..V_TOTAL-1
//   InDisplayArea  out  1   high when CounterX<H_VISIBLE and CounterY<V_VISIBLE
//   h_sync         out  1   horizontal sync, polarity HSYNC_POL
//   v_sync         out  1   vertical sync, polarity VSYNC_POL
//   line_start     out  1   high for the pixel period where CounterX==0
//   frame_start    out  1   high for the pixel period where CounterX==0 and CounterY==0
// BEHAVIOUR
//   H_TOTAL = sum of H_* (800 default); V_TOTAL = sum of V_* (525 default).
//   Reset: div_cnt=0, pix_en=0, CounterX=H_TOTAL-1, CounterY=V_TOTAL-1, InDisplayArea=0,
//     h_sync=~HSYNC_POL, v_sync=~VSYNC_POL, line_start=0, frame_start=0.
//   Divider: div_cnt counts 0..CLK_DIV-1 and wraps; pix_en is registered, high exactly one
//     cycle in every CLK_DIV (CLK_DIV=1: pix_en constantly high after reset release).
//     First pix_en occurs in the CLK_DIV-th cycle after RST deasserts.
//   Counters step on the CLK_50 edge where pix_en==1: CounterX+1; at H_TOTAL-1 wraps to 0
//     and CounterY+1; CounterY at V_TOTAL-1 with CounterX wrap goes to 0.
//   Hence first pix_en after reset moves counters to (0,0): first pixel of a full frame.
//   All decoded outputs are registered from next-state counter values, so they are
//   aligned with CounterX/CounterY in the same cycle (zero relative latency, glitch-free).
//   h_sync active iff H_VISIBLE+H_FRONT <= CounterX < H_VISIBLE+H_FRONT+H_SYNC.
//   v_sync active iff V_VISIBLE+V_FRONT <= CounterY < V_VISIBLE+V_FRONT+V_SYNC
//     (whole lines, transitions coincide with CounterX wrap to 0).
//   line_start/frame_start are level signals held for the full pixel period (CLK_DIV cycles).
//   RST asserted mid-frame: all state returns to reset values immediately (async);
//     after release timing restarts exactly as from power-up; no partial-line output.
//   Counter widths fixed at 10 bits; H_TOTAL and V_TOTAL must be <= 1024.
// TESTING
//   1. Hold RST 5 cycles -> all outputs at reset values; release -> pix_en first high on
//      cycle 2, then every 2nd cycle; counters (0,0), frame_start=1, InDisplayArea=1.
//   2. Run one line -> CounterX 0..799 then wraps, CounterY +1; h_sync low exactly for
//      CounterX 656..751 (96 pixels = 192 CLK_50 cycles); InDisplayArea low from X=640.
//   3. Run full frame -> v_sync low for CounterY 490..491 only; frame_start re-asserts
//      after exactly 800*525*2 = 840000 CLK_50 cycles; InDisplayArea low for Y>=480.
//   4. Assert RST at CounterX=300,CounterY=200 for 1 cycle -> outputs revert async;
//      after release next frame_start within 2 cycles, line sequence from X=0 intact.
//   5. Params CLK_DIV=1, HSYNC_POL=1, VSYNC_POL=1 -> pix_en constantly high, h_sync high
//      for X 656..751, v_sync high for Y 490..491, frame period 420000 cycles.
//   6. Check at every pix_en: line_start==(X==0), frame_start==(X==0&&Y==0), no
//      output changes on cycles with pix_en==0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for the VGA output path. CLK_50 is divided down to
//   a one-cycle pixel-rate enable. Horizontal and vertical counters advance on
//   that enable and feed the sync, display-area and line/frame-start decodes
//   that the downstream colour stage consumes.
//
// Ports
//   CLK_50         in   1   system clock
//   RST            in   1   asynchronous reset, active-high
//   pix_en         out  1   one-cycle pulse per pixel; all other outputs change with it
//   CounterX       out  10  horizontal position, 0..H_TOTAL-1
//   CounterY       out  10  vertical position, 0..V_TOTAL-1
//   InDisplayArea  out  1   CounterX < H_VISIBLE and CounterY < V_VISIBLE
//   h_sync         out  1   horizontal sync, active level HSYNC_POL
//   v_sync         out  1   vertical sync, active level VSYNC_POL
//   line_start     out  1   pixel period with CounterX == 0
//   frame_start    out  1   pixel period with CounterX == 0 and CounterY == 0
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic       CLK_50,
    input  logic       RST,
    output logic       pix_en,
    output logic [9:0] CounterX,
    output logic [9:0] CounterY,
    output logic       InDisplayArea,
    output logic       h_sync,
    output logic       v_sync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Decode bounds kept 11 bits wide so a sync pulse ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic HS_ACT = 1'(HSYNC_POL);
    localparam logic VS_ACT = 1'(VSYNC_POL);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             ida_q, ida_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;

    logic             adv;
    logic [10:0]      x_ext, y_ext;

    always_comb begin
        // The same edge that raises pix_en also steps the counters, so pix_en marks
        // the first CLK_50 cycle of each new pixel and the first pulse lands on (0,0).
        adv      = (div_q == DIV_LAST);
        div_d    = adv ? '0 : div_q + DIV_W'(1);
        pix_en_d = adv;

        x_d = x_q;
        y_d = y_q;
        if (adv) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        // Decodes come from the next-state counters so they register alongside them.
        x_ext = {1'b0, x_d};
        y_ext = {1'b0, y_d};
        ida_d = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
        hs_d  = ((x_ext >= HS_START) && (x_ext < HS_END)) ? HS_ACT : ~HS_ACT;
        vs_d  = ((y_ext >= VS_START) && (y_ext < VS_END)) ? VS_ACT : ~VS_ACT;
        ls_d  = (x_d == 10'd0);
        fs_d  = (x_d == 10'd0) && (y_d == 10'd0);
    end

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            x_q      <= H_LAST;
            y_q      <= V_LAST;
            ida_q    <= 1'b0;
            hs_q     <= ~HS_ACT;
            vs_q     <= ~VS_ACT;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ida_q    <= ida_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    assign pix_en        = pix_en_q;
    assign CounterX      = x_q;
    assign CounterY      = y_q;
    assign InDisplayArea = ida_q;
    assign h_sync        = hs_q;
    assign v_sync        = vs_q;
    assign line_start    = ls_q;
    assign frame_start   = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Three instances: default 640x480 timing at CLK_DIV=2, and two small rasters
//   (16x10 total) at CLK_DIV=1 with active-high syncs and CLK_DIV=3 with
//   active-low syncs, so complete frames fit in a short run.
module tb_vga_timing_gen;

    logic clk;
    logic rst_a, rst_b, rst_c;

    logic       pix_en_a, ida_a, hs_a, vs_a, ls_a, fs_a;
    logic [9:0] cx_a, cy_a;
    logic       pix_en_b, ida_b, hs_b, vs_b, ls_b, fs_b;
    logic [9:0] cx_b, cy_b;
    logic       pix_en_c, ida_c, hs_c, vs_c, ls_c, fs_c;
    logic [9:0] cx_c, cy_c;

    logic [25:0] obs_a, obs_b, obs_c;

    int checks   = 0;
    int failures = 0;
    int hs_low;
    int vs_cnt;

    vga_timing_gen u_dut_a (
        .CLK_50(clk), .RST(rst_a), .pix_en(pix_en_a),
        .CounterX(cx_a), .CounterY(cy_a), .InDisplayArea(ida_a),
        .h_sync(hs_a), .v_sync(vs_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1), .VSYNC_POL(1)
    ) u_dut_b (
        .CLK_50(clk), .RST(rst_b), .pix_en(pix_en_b),
        .CounterX(cx_b), .CounterY(cy_b), .InDisplayArea(ida_b),
        .h_sync(hs_b), .v_sync(vs_b), .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) u_dut_c (
        .CLK_50(clk), .RST(rst_c), .pix_en(pix_en_c),
        .CounterX(cx_c), .CounterY(cy_c), .InDisplayArea(ida_c),
        .h_sync(hs_c), .v_sync(vs_c), .line_start(ls_c), .frame_start(fs_c)
    );

    assign obs_a = {pix_en_a, cx_a, cy_a, ida_a, hs_a, vs_a, ls_a, fs_a};
    assign obs_b = {pix_en_b, cx_b, cy_b, ida_b, hs_b, vs_b, ls_b, fs_b};
    assign obs_c = {pix_en_c, cx_c, cy_c, ida_c, hs_c, vs_c, ls_c, fs_c};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired before the directed sequence ended");
        $fatal(1, "watchdog");
    end

    // Expected {pix_en,X,Y,ida,hs,vs,ls,fs} on the cycle after the k-th rising edge
    // following reset release (k=0 means still in reset).
    function automatic logic [25:0] exp_vec(input int k, input int div,
                                            input int hv, input int hf, input int hw, input int hb,
                                            input int vv, input int vf, input int vw, input int vb,
                                            input logic hpol, input logic vpol);
        int   ht, vt, p, x, y;
        logic pe, ida, hs, vs, ls, fs;
        ht = hv + hf + hw + hb;
        vt = vv + vf + vw + vb;
        if (k < div)
            return {1'b0, 10'(ht - 1), 10'(vt - 1), 1'b0, ~hpol, ~vpol, 1'b0, 1'b0};
        p   = (k / div - 1) % (ht * vt);
        x   = p % ht;
        y   = p / ht;
        pe  = ((k % div) == 0);
        ida = (x < hv) && (y < vv);
        hs  = (x >= hv + hf && x < hv + hf + hw) ? hpol : ~hpol;
        vs  = (y >= vv + vf && y < vv + vf + vw) ? vpol : ~vpol;
        ls  = (x == 0);
        fs  = (p == 0);
        return {pe, 10'(x), 10'(y), ida, hs, vs, ls, fs};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);

        chk("rst_a_pix_en", 32'(pix_en_a), 32'd0);
        chk("rst_a_x", 32'(cx_a), 32'd799);
        chk("rst_a_y", 32'(cy_a), 32'd524);
        chk("rst_a_ida", 32'(ida_a), 32'd0);
        chk("rst_a_syncs", 32'({hs_a, vs_a}), 32'd3);
        chk("rst_a_starts", 32'({ls_a, fs_a}), 32'd0);
        chk("rst_b_syncs", 32'({hs_b, vs_b}), 32'd0);
        chk("rst_b_xy", 32'({cx_b, cy_b}), 32'({10'd15, 10'd9}));

        // Default timing: first line plus part of the second, up to X=300 on line 1.
        rst_a  = 1'b0;
        hs_low = 0;
        for (int k = 1; k <= 2202; k++) begin
            @(negedge clk);
            chk($sformatf("a_k%0d", k), 32'(obs_a),
                32'(exp_vec(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0)));
            if (k >= 2 && k <= 1601 && hs_a == 1'b0) hs_low++;
            if (k == 1)
                chk("a_no_pix_en_cycle1", 32'({pix_en_a, cx_a}), 32'({1'b0, 10'd799}));
            if (k == 2)
                chk("a_first_pixel", 32'({pix_en_a, cx_a, cy_a, fs_a, ls_a, ida_a}),
                    32'({1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1}));
            if (k == 1282)
                chk("a_x640_blank", 32'({cx_a, ida_a}), 32'({10'd640, 1'b0}));
            if (k == 1602)
                chk("a_line1_start", 32'({cx_a, cy_a, ls_a, fs_a}),
                    32'({10'd0, 10'd1, 1'b1, 1'b0}));
        end
        chk("a_hsync_low_cycles", 32'(hs_low), 32'd192);
        chk("a_at_x300", 32'({cx_a, cy_a}), 32'({10'd300, 10'd1}));

        // Reset in the middle of a line must take effect without a clock edge.
        rst_a = 1'b1;
        #1;
        chk("a_async_rst", 32'(obs_a),
            32'({1'b0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        rst_a = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            chk($sformatf("a_restart_k%0d", k), 32'(obs_a),
                32'(exp_vec(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0)));
            if (k == 2)
                chk("a_restart_frame_start", 32'({fs_a, cx_a, cy_a}),
                    32'({1'b1, 10'd0, 10'd0}));
        end

        // CLK_DIV=1, active-high syncs: full 16x10 frame, frame period 160 cycles.
        rst_b  = 1'b0;
        vs_cnt = 0;
        for (int k = 1; k <= 161; k++) begin
            @(negedge clk);
            chk($sformatf("b_k%0d", k), 32'(obs_b),
                32'(exp_vec(k, 1, 8, 2, 3, 3, 6, 1, 2, 1, 1'b1, 1'b1)));
            if (k <= 160 && vs_b == 1'b1) vs_cnt++;
        end
        chk("b_vsync_high_cycles", 32'(vs_cnt), 32'd32);
        chk("b_frame_period", 32'({fs_b, pix_en_b, cx_b, cy_b}),
            32'({1'b1, 1'b1, 10'd0, 10'd0}));

        // CLK_DIV=3, active-low syncs: full frame, frame period 480 cycles.
        rst_c  = 1'b0;
        vs_cnt = 0;
        for (int k = 1; k <= 483; k++) begin
            @(negedge clk);
            chk($sformatf("c_k%0d", k), 32'(obs_c),
                32'(exp_vec(k, 3, 8, 2, 3, 3, 6, 1, 2, 1, 1'b0, 1'b0)));
            if (k >= 3 && k <= 482 && vs_c == 1'b0) vs_cnt++;
        end
        chk("c_vsync_low_cycles", 32'(vs_cnt), 32'd96);
        chk("c_frame_period", 32'({fs_c, pix_en_c, cx_c, cy_c}),
            32'({1'b1, 1'b1, 10'd0, 10'd0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
